// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one combinational 32-bit
// ripple-carry adder among NREQ requesters. Operands are registered before
// the adder, given ADD_WAIT settle cycles, then the tagged result is held
// until the consumer accepts it.
module adder_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int ADD_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_x,
  input  logic [32*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_carry,
  output logic                 busy
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_op_id;
  logic [31:0]     r_op_x;
  logic [31:0]     r_op_y;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_rot;
  logic            w_any;
  logic [IDW:0]    w_id_sum;
  logic [IDW-1:0]  w_gnt_id;
  logic [IDW-1:0]  w_next_ptr;
  logic [31:0]     w_sel_x;
  logic [31:0]     w_sel_y;
  logic [31:0]     w_add_sum;
  logic            w_add_co;
  logic            w_c;

  // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the lowest
  // set bit, then map the rotated position back to a requester index.
  always_comb begin
    w_rot    = NREQ'({req_valid, req_valid} >> r_rr_ptr);
    w_any    = 1'b0;
    w_id_sum = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any    = 1'b1;
        w_id_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      end
    end
    if (w_id_sum >= (IDW+1)'(NREQ)) begin
      w_id_sum = w_id_sum - (IDW+1)'(NREQ);
    end
    w_gnt_id   = w_id_sum[IDW-1:0];
    w_next_ptr = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
  end

  // Grant is offered only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && !reset && w_any) begin
      req_ready = NREQ'(1) << w_gnt_id;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (w_gnt_id == IDW'(j)) begin
        w_sel_x = req_x[32*j +: 32];
        w_sel_y = req_y[32*j +: 32];
      end
    end
  end

  // Shared ripple-carry adder, fed only from the operand registers.
  always_comb begin
    w_add_sum = '0;
    w_c       = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      w_add_sum[i] = r_op_x[i] ^ r_op_y[i] ^ w_c;
      w_c          = (r_op_x[i] & r_op_y[i]) | (w_c & (r_op_x[i] ^ r_op_y[i]));
    end
    w_add_co = w_c;
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_op_id   <= '0;
      r_op_x    <= '0;
      r_op_y    <= '0;
      r_cnt     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op_x   <= w_sel_x;
            r_op_y   <= w_sel_y;
            r_op_id  <= w_gnt_id;
            r_cnt    <= CW'(ADD_WAIT - 1);
            r_rr_ptr <= w_next_ptr;
            busy     <= 1'b1;
            r_state  <= S_ADD;
          end
        end
        S_ADD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            rsp_sum   <= w_add_sum;
            rsp_carry <= w_add_co;
            rsp_id    <= r_op_id;
            rsp_valid <= 1'b1;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
